// File: rtl/fetch_sequencer_if.sv
// Instruction-memory bus between the fetch sequencer and instruction memory.
//   i_req   : fetch request (sequencer -> memory)
//   i_addr  : word-aligned fetch address (sequencer -> memory)
//   i_ready : memory returns i_data this cycle (memory -> sequencer)
//   i_data  : instruction word (memory -> sequencer)
interface fetch_sequencer_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_data;

  modport master (output i_req, i_addr, input i_ready, i_data);
  modport slave  (input i_req, i_addr, output i_ready, i_data);
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer. Owns the PC, fetches one instruction at a time
// over a req/ready handshake, holds it in ir until the datapath retires it,
// then applies the decoder's jr/jump/jal/branch outcome to pick the next PC.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   imem (master)     : instruction-memory bus (i_req/i_addr out, i_ready/i_data in)
//   ir, ir_valid      : held instruction and its valid flag
//   retire            : datapath done with ir (only honoured while ir_valid)
//   jump, jal, jr, branch, nequal, zero, rs_data : control/operands for ir
//   pc, pc_plus4      : address of ir, and pc+4 (combinational link value)
//   misalign          : one-cycle pulse after retiring a jr with rs_data[1:0]!=0
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  fetch_sequencer_if.master         imem,
  output logic [31:0]               ir,
  output logic                      ir_valid,
  input  logic                      retire,
  input  logic                      jump,
  input  logic                      jal,
  input  logic                      jr,
  input  logic                      branch,
  input  logic                      nequal,
  input  logic                      zero,
  input  logic [31:0]               rs_data,
  output logic [31:0]               pc,
  output logic [31:0]               pc_plus4,
  output logic                      misalign
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

  state_t      state;
  logic        req_q;
  logic [31:0] addr_q;
  logic [31:0] next_pc;
  logic [31:0] br_off;
  logic        br_taken;

  assign imem.i_req  = req_q;
  assign imem.i_addr = addr_q;
  assign pc_plus4    = pc + 32'd4;

  // Branch offset: sign-extended word offset, added modulo 2^32.
  assign br_off   = {{14{ir[15]}}, ir[15:0], 2'b00};
  // beq takes on zero, bne takes on !zero.
  assign br_taken = branch & (zero ^ nequal);

  // Priority: jr > jump/jal > taken branch > fall-through.
  always_comb begin
    next_pc = pc_plus4;
    if (jr)
      next_pc = {rs_data[31:2], 2'b00};
    else if (jump | jal)
      next_pc = {pc_plus4[31:28], ir[25:0], 2'b00};
    else if (br_taken)
      next_pc = pc_plus4 + br_off;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
      ir       <= 32'd0;
      ir_valid <= 1'b0;
      misalign <= 1'b0;
    end else begin
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          state  <= FETCH;
          req_q  <= 1'b1;
          addr_q <= pc;
        end
        FETCH: begin
          if (imem.i_ready) begin
            ir       <= imem.i_data;
            ir_valid <= 1'b1;
            req_q    <= 1'b0;
            state    <= VALID;
          end
        end
        VALID: begin
          if (retire) begin
            pc       <= next_pc;
            addr_q   <= next_pc;
            req_q    <= 1'b1;
            ir_valid <= 1'b0;
            misalign <= jr & (|rs_data[1:0]);
            state    <= FETCH;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  typedef struct {
    logic [31:0] instr;
    logic        jr, jump, jal, branch, nequal, zero;
    logic [31:0] rs;
    int          waits;
    logic [31:0] exp_next;
    logic        exp_mis;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ir;
  logic        ir_valid;
  logic        retire;
  logic        jump, jal, jr, branch, nequal, zero;
  logic [31:0] rs_data;
  logic [31:0] pc, pc_plus4;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .imem     (bus.master),
    .ir       (ir),
    .ir_valid (ir_valid),
    .retire   (retire),
    .jump     (jump),
    .jal      (jal),
    .jr       (jr),
    .branch   (branch),
    .nequal   (nequal),
    .zero     (zero),
    .rs_data  (rs_data),
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .misalign (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Next-PC from the architectural rules, in plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input vec_t v);
    logic [31:0] p4;
    int          off;
    p4 = cur + 32'd4;
    if (v.jr) return v.rs - (v.rs % 32'd4);
    if (v.jump || v.jal) return (p4 & 32'hF000_0000) + (v.instr % 32'h0400_0000) * 32'd4;
    if (v.branch && (v.zero != v.nequal)) begin
      off = int'($signed(v.instr[15:0]));
      return p4 + 32'(off * 4);
    end
    return p4;
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, input logic j_r, j, j_l, b, ne, z,
                              input logic [31:0] rs, input int waits,
                              input logic [31:0] exp_next, input logic exp_mis);
    vec_t v;
    v.instr = instr; v.jr = j_r; v.jump = j; v.jal = j_l; v.branch = b;
    v.nequal = ne; v.zero = z; v.rs = rs; v.waits = waits;
    v.exp_next = exp_next; v.exp_mis = exp_mis;
    return v;
  endfunction

  task automatic clear_ctrl();
    jump = 0; jal = 0; jr = 0; branch = 0; nequal = 0; zero = 0; rs_data = 32'd0;
  endtask

  // One full instruction: wait for request, optional wait states, capture, retire.
  task automatic run_instr(input vec_t v, input logic [31:0] cur, input bit noisy);
    int n;
    n = 0;
    while (bus.i_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("req_up", {31'd0, bus.i_req}, 32'd1);
    chk("fetch_addr", bus.i_addr, cur);
    for (int w = 0; w < v.waits; w++) begin
      bus.i_ready = 1'b0;
      bus.i_data  = $urandom;
      retire      = noisy ? 1'($urandom % 2) : 1'b0;
      @(negedge clk);
      chk("wait_req", {31'd0, bus.i_req}, 32'd1);
      chk("wait_addr", bus.i_addr, cur);
      chk("wait_irv", {31'd0, ir_valid}, 32'd0);
      chk("wait_pc", pc, cur);
    end
    retire      = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_data  = v.instr;
    @(negedge clk);
    bus.i_ready = 1'b0;
    bus.i_data  = $urandom;
    chk("irv_set", {31'd0, ir_valid}, 32'd1);
    chk("ir_cap", ir, v.instr);
    chk("req_drop", {31'd0, bus.i_req}, 32'd0);
    chk("valid_pc", pc, cur);
    chk("pc_plus4", pc_plus4, cur + 32'd4);
    jr = v.jr; jump = v.jump; jal = v.jal; branch = v.branch;
    nequal = v.nequal; zero = v.zero; rs_data = v.rs;
    retire = 1'b1;
    @(negedge clk);
    retire = 1'b0;
    clear_ctrl();
    chk("next_addr", bus.i_addr, v.exp_next);
    chk("next_pc", pc, v.exp_next);
    chk("next_req", {31'd0, bus.i_req}, 32'd1);
    chk("misalign", {31'd0, misalign}, {31'd0, v.exp_mis});
    chk("irv_clr", {31'd0, ir_valid}, 32'd0);
    @(negedge clk);
    chk("mis_pulse", {31'd0, misalign}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"}, {31'd0, bus.i_req}, 32'd0);
    chk({tag, "_addr"}, bus.i_addr, 32'd0);
    chk({tag, "_ir"}, ir, 32'd0);
    chk({tag, "_irv"}, {31'd0, ir_valid}, 32'd0);
    chk({tag, "_pc"}, pc, 32'd0);
    chk({tag, "_mis"}, {31'd0, misalign}, 32'd0);
  endtask

  vec_t        tbl[16];
  vec_t        v;
  logic [31:0] cur;
  int          n;

  initial begin
    tbl[0]  = mk(32'h2408_0001, 0,0,0,0,0,0, 32'd0,          0, 32'h0000_0004, 0);
    tbl[1]  = mk(32'h2409_0002, 0,0,0,0,0,0, 32'd0,          3, 32'h0000_0008, 0);
    tbl[2]  = mk(32'h240A_0003, 0,0,0,0,0,0, 32'd0,          0, 32'h0000_000C, 0);
    tbl[3]  = mk(32'h0800_0040, 0,1,0,0,0,0, 32'd0,          0, 32'h0000_0100, 0);
    tbl[4]  = mk(32'h1000_FFFE, 0,0,0,1,0,1, 32'd0,          0, 32'h0000_00FC, 0);
    tbl[5]  = mk(32'h0800_0040, 0,1,0,0,0,0, 32'd0,          1, 32'h0000_0100, 0);
    tbl[6]  = mk(32'h1400_FFFE, 0,0,0,1,1,1, 32'd0,          0, 32'h0000_0104, 0);
    tbl[7]  = mk(32'h0000_0008, 1,0,0,0,0,0, 32'h4000_0010, 0, 32'h4000_0010, 0);
    tbl[8]  = mk(32'h0800_0040, 0,1,0,0,0,0, 32'd0,          0, 32'h4000_0100, 0);
    tbl[9]  = mk(32'h0800_0040, 1,1,0,0,0,0, 32'h0000_2003, 0, 32'h0000_2000, 1);
    tbl[10] = mk(32'h0C00_0010, 0,0,1,0,0,0, 32'd0,          2, 32'h0000_0040, 0);
    tbl[11] = mk(32'h1400_0004, 0,0,0,1,1,0, 32'd0,          0, 32'h0000_0054, 0);
    tbl[12] = mk(32'h0800_0080, 0,1,0,1,0,1, 32'd0,          0, 32'h0000_0200, 0);
    tbl[13] = mk(32'h0000_0008, 1,0,0,0,0,0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0);
    tbl[14] = mk(32'h0000_0000, 0,0,0,0,0,0, 32'd0,          0, 32'h0000_0000, 0);
    tbl[15] = mk(32'h1000_FFFF, 0,0,0,1,0,0, 32'd0,          0, 32'h0000_0004, 0);

    rst_n = 1'b0; retire = 1'b0; bus.i_ready = 1'b0; bus.i_data = 32'd0;
    clear_ctrl();
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    chk("rst_pc4", pc_plus4, 32'd4);
    rst_n = 1'b1;
    #1 chk("idle_req", {31'd0, bus.i_req}, 32'd0);
    @(negedge clk);
    chk("first_req", {31'd0, bus.i_req}, 32'd1);
    chk("first_addr", bus.i_addr, 32'd0);

    cur = 32'd0;
    for (int i = 0; i < 16; i++) begin
      run_instr(tbl[i], cur, 1'b0);
      cur = tbl[i].exp_next;
    end

    for (int i = 0; i < 40; i++) begin
      v.instr  = $urandom;
      v.jr     = ($urandom % 5 == 0);
      v.jump   = ($urandom % 4 == 0);
      v.jal    = ($urandom % 6 == 0);
      v.branch = ($urandom % 2 == 0);
      v.nequal = 1'($urandom % 2);
      v.zero   = 1'($urandom % 2);
      v.rs     = $urandom;
      v.waits  = $urandom % 3;
      v.exp_next = ref_next(cur, v);
      v.exp_mis  = v.jr && (v.rs % 32'd4 != 0);
      run_instr(v, cur, 1'b1);
      cur = v.exp_next;
    end

    // Async reset while fetch is completing (i_req=1, i_ready=1).
    n = 0;
    while (bus.i_req !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    bus.i_ready = 1'b1; bus.i_data = 32'hDEAD_BEEF;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("arst_fetch");
    @(negedge clk);
    chk("arst_ir_hold", ir, 32'd0);
    bus.i_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_req", {31'd0, bus.i_req}, 32'd1);
    chk("restart_addr", bus.i_addr, 32'd0);
    run_instr(tbl[0], 32'd0, 1'b0);

    // Async reset while an instruction is held.
    bus.i_ready = 1'b1; bus.i_data = 32'h1234_5678;
    @(negedge clk);
    bus.i_ready = 1'b0;
    chk("held_ir", ir, 32'h1234_5678);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("arst_valid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart2_addr", bus.i_addr, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
